// File: rtl/uart_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam logic [2:0] UART_TXDATA_OFS = 3'd0;
   localparam logic [2:0] UART_STATUS_OFS = 3'd4;

   localparam int STAT_FULL   = 0;
   localparam int STAT_EMPTY  = 1;
   localparam int STAT_ACTIVE = 2;
   localparam int STAT_OVF    = 3;

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Single-clock FIFO for the UART byte queue; dout shows the head entry combinationally.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PW   = $clog2(DEPTH);
   localparam int CNTW = PW + 1;

   // push is taken when not full or when a pop frees the head in the same cycle;
   // pop is taken only when non-empty; dout is valid whenever empty is low.
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]  count_q, count_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == CNTW'(DEPTH));
   assign empty   = (count_q == '0);
   assign dout    = mem_q[rd_ptr_q];
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CNTW'(push_ok) - CNTW'(pop_ok);
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS window, byte FIFO, serialiser FSM.
module uart_tx_mmio
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] addr,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        tx,
   output logic        busy
);

   localparam int            CW      = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

   uart_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic          tx_q, tx_d;
   logic          ovf_q, ovf_d;

   logic       sel, is_txdata, is_status, wr_data, wr_status;
   logic       fifo_pop, fifo_full, fifo_empty;
   logic [7:0] fifo_dout;
   logic [2:0] reg_ofs;
   logic       unused_bits;

   assign sel         = (addr[31:3] == BASE_ADDR[31:3]);
   assign reg_ofs     = {addr[2], 2'b00};
   assign is_txdata   = (reg_ofs == UART_TXDATA_OFS);
   assign is_status   = (reg_ofs == UART_STATUS_OFS);
   assign wr_data     = memwrite & sel & is_txdata;
   assign wr_status   = memwrite & sel & is_status;
   assign unused_bits = ^{addr[1:0], wd[31:8]};

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_data),
      .pop   (fifo_pop),
      .din   (wd[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A dropped byte outranks a same-cycle clear so no loss goes unreported.
   always_comb begin
      ovf_d = ovf_q;
      if (wr_status && wd[STAT_OVF]) ovf_d = 1'b0;
      if (wr_data && fifo_full && !fifo_pop) ovf_d = 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      fifo_pop  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_dout;
               cnt_d    = CNT_MAX;
               state_d  = START;
            end
         end
         START: begin
            if (cnt_q == '0) begin
               cnt_d     = CNT_MAX;
               bit_idx_d = 3'd0;
               state_d   = DATA;
            end else cnt_d = cnt_q - CW'(1);
         end
         DATA: begin
            if (cnt_q == '0) begin
               cnt_d     = CNT_MAX;
               shift_d   = shift_q >> 1;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = STOP;
            end else cnt_d = cnt_q - CW'(1);
         end
         STOP: begin
            if (cnt_q == '0) begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_dout;
                  cnt_d    = CNT_MAX;
                  state_d  = START;
               end else state_d = IDLE;
            end else cnt_d = cnt_q - CW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   // tx is decoded from the next state so the line flop changes on the same edge as the FSM.
   always_comb begin
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         shift_q   <= '0;
         bit_idx_q <= '0;
         tx_q      <= 1'b1;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         tx_q      <= tx_d;
         ovf_q     <= ovf_d;
      end
   end

   always_comb begin
      rd = '0;
      if (sel && is_status) begin
         rd[STAT_FULL]   = fifo_full;
         rd[STAT_EMPTY]  = fifo_empty;
         rd[STAT_ACTIVE] = (state_q != IDLE);
         rd[STAT_OVF]    = ovf_q;
      end
   end

   assign tx   = tx_q;
   assign busy = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: frame-position model checked every cycle plus directed literal checks.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int C = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] addr = BASE + 32'd4;
  logic [31:0] wd = 32'd0;
  logic [31:0] rd;
  logic        tx;
  logic        busy;

  always #5 clk = ~clk;

  uart_tx_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .memwrite (memwrite),
    .addr     (addr),
    .wd       (wd),
    .rd       (rd),
    .tx       (tx),
    .busy     (busy)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  logic [7:0] mq[$];
  bit         m_active = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_byte = 8'd0;
  bit         m_ovf = 1'b0;

  function automatic logic exp_bit(input logic [7:0] b, input int pos);
    int k;
    k = pos / C;
    if (k == 0) return 1'b0;
    else if (k <= 8) return b[k-1];
    else return 1'b1;
  endfunction

  function automatic logic [31:0] model_status();
    return {28'd0, m_ovf, m_active, (mq.size() == 0), (mq.size() == D)};
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (a[31:3] != BASE[31:3]) return 32'd0;
    return a[2] ? model_status() : 32'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit do_pop;
    do_pop = 1'b0;
    if (reset) begin
      mq.delete();
      m_active = 1'b0;
      m_pos = 0;
      m_ovf = 1'b0;
    end else begin
      if (!m_active) begin
        if (mq.size() > 0) do_pop = 1'b1;
      end else if (m_pos == 10*C - 1) begin
        if (mq.size() > 0) do_pop = 1'b1;
        else m_active = 1'b0;
      end else m_pos++;
      if (do_pop) begin
        m_byte = mq.pop_front();
        m_active = 1'b1;
        m_pos = 0;
      end
      if (memwrite && addr[31:3] == BASE[31:3] && !addr[2]) begin
        if (mq.size() < D) mq.push_back(wd[7:0]);
        else m_ovf = 1'b1;
      end else if (memwrite && addr[31:3] == BASE[31:3] && addr[2] && wd[3]) begin
        m_ovf = 1'b0;
      end
    end
  endtask

  // Compare process: model advances on each rising edge, outputs checked on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
      @(negedge clk);
      check("tx", 32'(tx), 32'(m_active ? exp_bit(m_byte, m_pos) : 1'b1));
      check("busy", 32'(busy), 32'(m_active || mq.size() > 0));
      check("rd", rd, model_rd(addr));
    end
  end

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic wait_edge(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, output int n);
    memwrite = 1'b1;
    addr = a;
    wd = d;
    @(posedge clk);
    #2;
    memwrite = 1'b0;
    addr = BASE + 32'd4;
    wd = 32'd0;
    n = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish, cycle %0d", cyc);
    err_cnt++;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    int n, n1, e, dummy;
    logic exp_a5 [10];
    exp_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    #1 check("rst_status", rd, 32'h2);

    store(BASE, 32'hFFFF_FFA5, n);
    check("a5_busy_after_push", 32'(busy), 32'd1);
    for (int k = 0; k < 10; k++) begin
      wait_edge(n + 1 + k*C + C/2);
      check($sformatf("a5_bit%0d", k), 32'(tx), 32'(exp_a5[k]));
    end
    wait_edge(n + 40);
    check("a5_busy_in_stop", 32'(busy), 32'd1);
    wait_edge(n + 41);
    check("a5_busy_drop", 32'(busy), 32'd0);

    store(BASE, 32'h01, n);
    store(BASE, 32'h02, n1);
    wait_edge(n + 1);
    check("b2b_start1", 32'(tx), 32'd0);
    wait_edge(n1 + 39);
    check("b2b_stop1", 32'(tx), 32'd1);
    wait_edge(n1 + 40);
    check("b2b_start2", 32'(tx), 32'd0);
    wait_edge(n + 81);
    check("b2b_done", 32'(busy), 32'd0);

    store(BASE, 32'h10, e);
    for (int i = 1; i < 6; i++) store(BASE, 32'h10 + 32'(i), dummy);
    #1 check("ovf_status", rd, 32'hD);
    store(BASE + 32'd4, 32'h8, dummy);
    #1 check("ovf_clear", rd, 32'h5);
    wait_edge(e + 200);
    check("ovf_last_frame", 32'(busy), 32'd1);
    wait_edge(e + 201);
    check("ovf_5_frames", 32'(busy), 32'd0);

    store(BASE + 32'd8, 32'h33, dummy);
    check("dec_plus8_busy", 32'(busy), 32'd0);
    #1 check("dec_plus8_status", rd, 32'h2);
    store(32'h0000_0054, 32'h44, dummy);
    check("dec_54_busy", 32'(busy), 32'd0);
    store(BASE + 32'd4, 32'hFFFF_FFF7, dummy);
    #1 check("dec_status_wr_ignored", rd, 32'h2);
    store(BASE + 32'd1, 32'h5A, n);
    check("dec_plus1_push", 32'(busy), 32'd1);
    addr = BASE;
    #1 check("dec_txdata_read", rd, 32'd0);
    addr = BASE + 32'd4;
    wait_edge(n + 42);
    check("dec_plus1_done", 32'(busy), 32'd0);

    store(BASE, 32'h00, n);
    store(BASE, 32'h81, dummy);
    store(BASE, 32'h7E, dummy);
    wait_edge(n + 18);
    check("mid_bit3", 32'(tx), 32'd0);
    reset = 1'b1;
    idle(1);
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    idle(60);
    check("mid_no_frames_busy", 32'(busy), 32'd0);
    check("mid_no_frames_tx", 32'(tx), 32'd1);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
